// File: rtl/redux_pkg.sv
// redux_pkg: shared widths, reset PC and fetch state encoding for the Redux-V core
package redux_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W = 16;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 8'h00;
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-stage bus (imem port, IR handshake to decode, redirect/halt control, status)
// master = fetch unit side, slave = memory/decoder/control side
interface fetch_unit_if import redux_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] ir_pc;
  logic ir_valid;
  logic ir_ready;
  logic redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic halt;
  logic halted;
  logic [CNT_W-1:0] fetch_cnt;
  logic pc_fault;
  modport master (
    output imem_addr, ir, ir_pc, ir_valid, halted, fetch_cnt, pc_fault,
    input imem_data, ir_ready, redirect_valid, redirect_target, halt
  );
  modport slave (
    input imem_addr, ir, ir_pc, ir_valid, halted, fetch_cnt, pc_fault,
    output imem_data, ir_ready, redirect_valid, redirect_target, halt
  );
endinterface

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with load/increment/hold; wrap flags pc at all-ones
// ports: clk, rst (async high), load+target, inc, pc, wrap
module fetch_pc_reg import redux_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [ADDR_W-1:0] target,
  input  logic inc,
  output logic [ADDR_W-1:0] pc,
  output logic wrap
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  always_comb pc_d = load ? target : inc ? pc_q + 1'b1 : pc_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  assign pc = pc_q;
  assign wrap = &pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: Redux-V fetch stage -- PC, imem address, IR with valid/ready to decode, redirect/halt
// ports: clk, rst (async high), bus (fetch_unit_if.master)
// FETCH_PC_WRAP_TRAP_EN: a load at pc all-ones delivers the instruction, then raises pc_fault and enters FAULT
module fetch_unit import redux_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  fetch_unit_if.master bus
);
`ifdef FETCH_PC_WRAP_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  logic [1:0] state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic ir_valid_q, ir_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pc_fault_q, pc_fault_d;
  logic [ADDR_W-1:0] pc;
  logic pc_wrap, run, halted, halt_go, redir, load, trap;
  fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .load(redir),
    .target(bus.redirect_target),
    .inc(load & ~trap),
    .pc(pc),
    .wrap(pc_wrap)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_BOOT;
    else state_q <= state_d;
  always_comb
    state_d = state_q == ST_BOOT ? ST_RUN : halt_go ? ST_HALTED : trap ? ST_FAULT : state_q;
  always_comb begin
    run = state_q == ST_RUN;
    halted = state_q == ST_HALTED || state_q == ST_FAULT;
  end
  // halt beats redirect, redirect beats load
  always_comb begin
    halt_go = run & bus.halt;
    redir = run & ~bus.halt & bus.redirect_valid;
    load = run & ~bus.halt & ~bus.redirect_valid & (~ir_valid_q | bus.ir_ready);
    trap = TRAP_EN & load & pc_wrap;
    ir_d = load ? bus.imem_data : ir_q;
    ir_pc_d = load ? pc : ir_pc_q;
    ir_valid_d = load | (ir_valid_q & ~bus.ir_ready & ~halt_go & ~redir);
    cnt_d = (load & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    pc_fault_d = pc_fault_q | trap;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ir_q <= '0;
      ir_pc_q <= '0;
      ir_valid_q <= 1'b0;
      cnt_q <= '0;
      pc_fault_q <= 1'b0;
    end else begin
      ir_q <= ir_d;
      ir_pc_q <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      cnt_q <= cnt_d;
      pc_fault_q <= pc_fault_d;
    end
  assign bus.imem_addr = pc;
  assign bus.ir = ir_q;
  assign bus.ir_pc = ir_pc_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.halted = halted;
  assign bus.fetch_cnt = cnt_q;
  assign bus.pc_fault = pc_fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a cycle-level reference model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] mem [256];
  int vectors = 0;
  int miscompares = 0;
  fetch_unit_if bus();
  fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.imem_data = mem[bus.imem_addr];
  always #5 clk = ~clk;
  // reference model: mode 0 boot, 1 run, 2 halted, 3 fault
  logic [7:0] m_pc, m_ir, m_irpc;
  logic m_v, m_fault;
  logic [15:0] m_cnt;
  int m_mode;
  function automatic logic [42:0] dut_vec();
    return {bus.imem_addr, bus.ir, bus.ir_pc, bus.ir_valid, bus.halted, bus.fetch_cnt, bus.pc_fault};
  endfunction
  function automatic logic [42:0] ref_vec();
    return {m_pc, m_ir, m_irpc, m_v, m_mode >= 2, m_cnt, m_fault};
  endfunction
  task automatic model_reset();
    m_pc = 8'h00; m_ir = 8'h00; m_irpc = 8'h00; m_v = 1'b0; m_fault = 1'b0; m_cnt = 16'h0; m_mode = 0;
  endtask
  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.ir_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 8'h00; bus.halt = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic cyc(input bit rdy, input bit rv, input logic [7:0] tgt, input bit h);
    bus.ir_ready = rdy; bus.redirect_valid = rv; bus.redirect_target = tgt; bus.halt = h;
    if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (h) begin
        m_v = 1'b0; m_mode = 2;
      end else if (rv) begin
        m_pc = tgt; m_v = 1'b0;
      end else if (!m_v || rdy) begin
        m_ir = mem[m_pc]; m_irpc = m_pc; m_v = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
`ifdef FETCH_PC_WRAP_TRAP_EN
        if (m_pc == 8'hFF) begin
          m_fault = 1'b1; m_mode = 3;
        end else m_pc = m_pc + 1;
`else
        m_pc = m_pc + 1;
`endif
      end
    end else if (rdy) m_v = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    fill_mem();
    rst = 1'b1;
    bus.ir_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_target = 8'h00; bus.halt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (dut_vec() !== 43'h0) begin
      miscompares++;
      $display("FAIL reset_state dut=%h want=%h", dut_vec(), 43'h0);
    end
  endtask
  task automatic test_stream();
    logic [7:0] exp_ir [4] = '{8'hB0, 8'hB5, 8'hBA, 8'hBF};
    fill_mem();
    for (int i = 0; i < 4; i++) mem[i] = exp_ir[i];
    do_reset();
    cyc(1, 0, 0, 0);
    vectors++;
    if (bus.ir_valid !== 1'b0 || dut_vec() !== ref_vec()) begin
      miscompares++;
      $display("FAIL stream_boot dut=%h want=%h", dut_vec(), ref_vec());
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0);
      vectors++;
      if (bus.ir !== exp_ir[i] || bus.ir_pc !== 8'(i) || bus.ir_valid !== 1'b1 || dut_vec() !== ref_vec()) begin
        miscompares++;
        $display("FAIL stream_%0d ir=%h ir_pc=%h dut=%h want ir=%h ir_pc=%h vec=%h", i, bus.ir, bus.ir_pc, dut_vec(), exp_ir[i], 8'(i), ref_vec());
      end
    end
    vectors++;
    if (bus.fetch_cnt !== 16'd4) begin
      miscompares++;
      $display("FAIL stream_cnt fetch_cnt=%0d want=4", bus.fetch_cnt);
    end
  endtask
  task automatic test_stall();
    fill_mem();
    mem[0] = 8'hB0; mem[1] = 8'hB5; mem[2] = 8'hBA;
    do_reset();
    repeat (3) cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      vectors++;
      if (bus.ir !== 8'hB5 || bus.ir_pc !== 8'h01 || bus.imem_addr !== 8'h02 || dut_vec() !== ref_vec()) begin
        miscompares++;
        $display("FAIL stall_%0d dut=%h want=%h (ir B5, ir_pc 01, pc 02)", i, dut_vec(), ref_vec());
      end
    end
    cyc(1, 0, 0, 0);
    vectors++;
    if (bus.ir !== 8'hBA || dut_vec() !== ref_vec()) begin
      miscompares++;
      $display("FAIL stall_release ir=%h want=BA dut=%h ref=%h", bus.ir, dut_vec(), ref_vec());
    end
  endtask
  task automatic test_redirect();
    fill_mem();
    do_reset();
    repeat (3) cyc(1, 0, 0, 0);
    cyc(1, 1, 8'h14, 0);
    vectors++;
    if (bus.ir_valid !== 1'b0 || bus.imem_addr !== 8'h14 || dut_vec() !== ref_vec()) begin
      miscompares++;
      $display("FAIL redirect_flush dut=%h want=%h", dut_vec(), ref_vec());
    end
    cyc(1, 0, 0, 0);
    vectors++;
    if (bus.ir_pc !== 8'h14 || bus.ir !== mem[8'h14] || dut_vec() !== ref_vec()) begin
      miscompares++;
      $display("FAIL redirect_target ir_pc=%h want=14 dut=%h ref=%h", bus.ir_pc, dut_vec(), ref_vec());
    end
  endtask
  task automatic test_halt_redirect();
    fill_mem();
    do_reset();
    repeat (3) cyc(1, 0, 0, 0);
    cyc(1, 1, 8'h40, 1);
    vectors++;
    if (bus.halted !== 1'b1 || bus.ir_valid !== 1'b0 || bus.imem_addr !== 8'h02 || dut_vec() !== ref_vec()) begin
      miscompares++;
      $display("FAIL halt_redirect dut=%h want=%h", dut_vec(), ref_vec());
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      vectors++;
      if (bus.halted !== 1'b1 || dut_vec() !== ref_vec()) begin
        miscompares++;
        $display("FAIL halted_hold_%0d dut=%h want=%h", i, dut_vec(), ref_vec());
      end
    end
  endtask
  task automatic test_wrap();
    fill_mem();
    do_reset();
    repeat (2) cyc(1, 0, 0, 0);
    cyc(1, 1, 8'hFF, 0);
    cyc(1, 0, 0, 0);
    vectors++;
`ifdef FETCH_PC_WRAP_TRAP_EN
    if (bus.ir_pc !== 8'hFF || bus.pc_fault !== 1'b1 || bus.halted !== 1'b1 || bus.imem_addr !== 8'hFF || dut_vec() !== ref_vec()) begin
`else
    if (bus.ir_pc !== 8'hFF || bus.pc_fault !== 1'b0 || bus.imem_addr !== 8'h00 || dut_vec() !== ref_vec()) begin
`endif
      miscompares++;
      $display("FAIL wrap_ff dut=%h want=%h", dut_vec(), ref_vec());
    end
    cyc(1, 0, 0, 0);
    vectors++;
`ifdef FETCH_PC_WRAP_TRAP_EN
    if (bus.ir_valid !== 1'b0 || bus.ir_pc !== 8'hFF || dut_vec() !== ref_vec()) begin
`else
    if (bus.ir_pc !== 8'h00 || bus.ir_valid !== 1'b1 || dut_vec() !== ref_vec()) begin
`endif
      miscompares++;
      $display("FAIL wrap_next dut=%h want=%h", dut_vec(), ref_vec());
    end
  endtask
  task automatic test_async_reset();
    fill_mem();
    do_reset();
    repeat (3) cyc(1, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (dut_vec() !== 43'h0) begin
      miscompares++;
      $display("FAIL async_reset dut=%h want=%h", dut_vec(), 43'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    vectors++;
    if (bus.ir_pc !== 8'h00 || bus.ir !== mem[0] || dut_vec() !== ref_vec()) begin
      miscompares++;
      $display("FAIL async_refetch dut=%h want=%h", dut_vec(), ref_vec());
    end
  endtask
  task automatic test_random();
    fill_mem();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_mode >= 2 && $urandom_range(0, 7) == 0) do_reset();
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
          $urandom_range(0, 3) == 0 ? 8'hFD : 8'($urandom), $urandom_range(0, 149) == 0);
      vectors++;
      if (dut_vec() !== ref_vec()) begin
        miscompares++;
        $display("FAIL random_%0d dut=%h want=%h", i, dut_vec(), ref_vec());
      end
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
